// File: rtl/image_half_scale_pkg.sv
// Shared constants and helpers for the image_half_scale 2x2 box-filter downscaler.
// Build option: define IMAGE_HALF_SCALE_ROUND_EN to round the average half-up
// instead of truncating it.
package image_half_scale_pkg;

  // Number of colour channels packed into one pixel (R in the MSBs, then G, then B).
  localparam int NUM_CH = 3;

  // Width of the column and row counters; covers frames up to 2048x2048.
  localparam int CNT_W = 11;

  // Width of one colour channel for a given pixel width.
  function automatic int ch_width(input int data_width);
    return data_width / NUM_CH;
  endfunction

endpackage

// File: rtl/image_half_scale_avg4.sv
// image_avg4: averages four samples of one colour channel.
// Stage 1 registers the full-precision sum; stage 2 registers the shifted
// (and optionally rounded) average. Both stages are load-enabled so the
// output holds its last value between accepted windows.
// Build option: IMAGE_HALF_SCALE_ROUND_EN selects (sum+2)>>2 over sum>>2.
module image_avg4 #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sum_en_i,
  input  logic          avg_en_i,
  input  logic [CW-1:0] pix0_i,
  input  logic [CW-1:0] pix1_i,
  input  logic [CW-1:0] pix2_i,
  input  logic [CW-1:0] pix3_i,
  output logic [CW-1:0] avg_o
);

  // Two extra bits hold the sum of four full-scale samples without overflow.
  localparam int SW = CW + 2;

  logic [SW-1:0] sum_d;
  logic [SW-1:0] sum_q;
  logic [SW-1:0] rnd;
  logic [CW-1:0] avg_d;
  logic [CW-1:0] avg_q;

  // Full-precision sum of the four window samples.
  always_comb begin
    sum_d = {2'b00, pix0_i} + {2'b00, pix1_i} + {2'b00, pix2_i} + {2'b00, pix3_i};
  end

  // Stage 1: capture the sum only for accepted windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (sum_en_i) begin
      sum_q <= sum_d;
    end
  end

  // Divide by four; the rounding offset cannot overflow since 4*max+2 < 2^SW.
  always_comb begin
`ifdef IMAGE_HALF_SCALE_ROUND_EN
    rnd = sum_q + SW'(2);
`else
    rnd = sum_q;
`endif
    avg_d = CW'(rnd >> 2);
  end

  // Stage 2: update the averaged sample when a stage-1 result is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_q <= '0;
    end else if (avg_en_i) begin
      avg_q <= avg_d;
    end
  end

  assign avg_o = avg_q;

endmodule

// File: rtl/image_half_scale.sv
// image_half_scale: 2x2 box-filter downscaler fed by a 2x2 window generator.
// Emits one averaged pixel for every complete, non-overlapping 2x2 block
// (odd column and odd row of the window position), giving a half-width,
// half-height stream. Sync signals travel through a matching 2-stage delay.
// Build option: IMAGE_HALF_SCALE_ROUND_EN enables round-half-up averaging.
module image_half_scale
  import image_half_scale_pkg::*;
#(
  parameter int DATA_WIDTH    = 24,
  parameter int FRAME_H_PIXEL = 1920,
  parameter int FRAME_V_PIXEL = 1080
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_rst,
  input  logic                  frame_i_vs,
  input  logic                  frame_i_hs,
  input  logic                  frame_i_valid,
  input  logic [DATA_WIDTH-1:0] frame_i_data_0,
  input  logic [DATA_WIDTH-1:0] frame_i_data_1,
  input  logic [DATA_WIDTH-1:0] frame_i_data_2,
  input  logic [DATA_WIDTH-1:0] frame_i_data_3,
  output logic                  frame_o_vs,
  output logic                  frame_o_hs,
  output logic                  frame_o_valid,
  output logic [DATA_WIDTH-1:0] frame_o_data
);

  localparam int CW = ch_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(FRAME_H_PIXEL - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(FRAME_V_PIXEL - 1);

  logic [CNT_W-1:0] col_q;
  logic [CNT_W-1:0] col_d;
  logic [CNT_W-1:0] row_q;
  logic [CNT_W-1:0] row_d;
  logic [CNT_W-1:0] col_cur;
  logic [CNT_W-1:0] row_cur;
  logic             vs_prev_q;
  logic             vs_rise;
  logic             accept;

  logic             valid1_q;
  logic             valid1_d;
  logic             vs1_q;
  logic             vs1_d;
  logic             hs1_q;
  logic             hs1_d;
  logic             valid2_q;
  logic             valid2_d;
  logic             vs2_q;
  logic             vs2_d;
  logic             hs2_q;
  logic             hs2_d;
  logic             avg_en;

  // Window position tracking: a vs rising edge makes the current cycle col 0,
  // row 0, so a valid on that same cycle is counted as the first pixel.
  always_comb begin
    vs_rise = frame_i_vs & ~vs_prev_q;
    col_cur = vs_rise ? '0 : col_q;
    row_cur = vs_rise ? '0 : row_q;
    accept  = frame_i_valid & col_cur[0] & row_cur[0] & ~frame_rst;
    col_d   = col_cur;
    row_d   = row_cur;
    if (frame_rst) begin
      col_d = '0;
      row_d = '0;
    end else if (frame_i_valid) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + CNT_W'(1);
      end else begin
        col_d = col_cur + CNT_W'(1);
      end
    end
  end

  // Counter and vs edge-detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      vs_prev_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      vs_prev_q <= frame_i_vs;
    end
  end

  // Valid and sync pipeline next-state; frame_rst flushes both stages.
  always_comb begin
    valid1_d = accept;
    vs1_d    = frame_i_vs;
    hs1_d    = frame_i_hs;
    valid2_d = valid1_q;
    vs2_d    = vs1_q;
    hs2_d    = hs1_q;
    avg_en   = valid1_q & ~frame_rst;
    if (frame_rst) begin
      valid1_d = 1'b0;
      vs1_d    = 1'b0;
      hs1_d    = 1'b0;
      valid2_d = 1'b0;
      vs2_d    = 1'b0;
      hs2_d    = 1'b0;
    end
  end

  // Stage 1 and stage 2 valid/sync registers, aligned with the data stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_q <= 1'b0;
      vs1_q    <= 1'b0;
      hs1_q    <= 1'b0;
      valid2_q <= 1'b0;
      vs2_q    <= 1'b0;
      hs2_q    <= 1'b0;
    end else begin
      valid1_q <= valid1_d;
      vs1_q    <= vs1_d;
      hs1_q    <= hs1_d;
      valid2_q <= valid2_d;
      vs2_q    <= vs2_d;
      hs2_q    <= hs2_d;
    end
  end

  // One averaging datapath per colour channel; channel gi sits at bits gi*CW.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    image_avg4 #(
      .CW(CW)
    ) u_avg4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .sum_en_i(accept),
      .avg_en_i(avg_en),
      .pix0_i  (frame_i_data_0[gi*CW +: CW]),
      .pix1_i  (frame_i_data_1[gi*CW +: CW]),
      .pix2_i  (frame_i_data_2[gi*CW +: CW]),
      .pix3_i  (frame_i_data_3[gi*CW +: CW]),
      .avg_o   (frame_o_data[gi*CW +: CW])
    );
  end

  assign frame_o_valid = valid2_q;
  assign frame_o_vs    = vs2_q;
  assign frame_o_hs    = hs2_q;

endmodule

// File: tb/tb_image_half_scale.sv
// Self-checking bench for image_half_scale on a small 8x4 frame.
// The reference model tracks the linear pixel index within the frame and
// derives column/row, block acceptance and per-channel averages arithmetically.
module tb_image_half_scale;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int NPIX = H * V;
  localparam int MAXT = 4096;
`ifdef IMAGE_HALF_SCALE_ROUND_EN
  localparam int ROUND_ADD = 2;
  localparam logic [23:0] ROUND_R = 24'd2;
`else
  localparam int ROUND_ADD = 0;
  localparam logic [23:0] ROUND_R = 24'd1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_rst = 1'b0;
  logic        vs = 1'b0;
  logic        hs = 1'b0;
  logic        valid = 1'b0;
  logic [23:0] d0 = '0;
  logic [23:0] d1 = '0;
  logic [23:0] d2 = '0;
  logic [23:0] d3 = '0;
  logic        o_vs;
  logic        o_hs;
  logic        o_valid;
  logic [23:0] o_data;

  always #5 clk = ~clk;

  image_half_scale #(
    .DATA_WIDTH   (24),
    .FRAME_H_PIXEL(H),
    .FRAME_V_PIXEL(V)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_rst     (frame_rst),
    .frame_i_vs    (vs),
    .frame_i_hs    (hs),
    .frame_i_valid (valid),
    .frame_i_data_0(d0),
    .frame_i_data_1(d1),
    .frame_i_data_2(d2),
    .frame_i_data_3(d3),
    .frame_o_vs    (o_vs),
    .frame_o_hs    (o_hs),
    .frame_o_valid (o_valid),
    .frame_o_data  (o_data)
  );

  int          checks = 0;
  int          errors = 0;
  int          t = 0;
  bit          frst_h[MAXT];
  bit          vs_h[MAXT];
  bit          hs_h[MAXT];
  bit          acc_h[MAXT];
  logic [23:0] dat_h[MAXT];
  int          pos = 0;
  bit          prev_vs = 1'b0;
  logic [23:0] last_data = '0;
  logic [23:0] dut_last = '0;
  int          out_cnt = 0;

  function automatic logic [23:0] ref_avg(input logic [23:0] a, input logic [23:0] b,
                                          input logic [23:0] c, input logic [23:0] d);
    logic [23:0] r;
    int s;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = int'(a[ch*8 +: 8]) + int'(b[ch*8 +: 8]) + int'(c[ch*8 +: 8]) + int'(d[ch*8 +: 8]);
      s = s + ROUND_ADD;
      r[ch*8 +: 8] = 8'(s / 4);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d got %h want %h", tag, t, got, exp);
    end
  endtask

  // One clock: record model inputs, advance the reference, then compare outputs.
  task automatic tick();
    bit f;
    bit rise;
    bit acc;
    bit ev;
    bit evs;
    bit ehs;
    int col;
    int row;
    if (t >= MAXT) begin
      $display("FAIL tick_budget got %0d want below %0d", t, MAXT);
      $fatal(1, "tick budget exhausted");
    end
    f = frame_rst || !rst_n;
    frst_h[t] = f;
    vs_h[t]   = vs;
    hs_h[t]   = hs;
    dat_h[t]  = ref_avg(d0, d1, d2, d3);
    acc = 1'b0;
    if (!rst_n) begin
      pos = 0;
      prev_vs = 1'b0;
    end else begin
      rise = vs && !prev_vs;
      prev_vs = vs;
      if (f) begin
        pos = 0;
      end else begin
        if (rise) pos = 0;
        if (valid) begin
          col = pos % H;
          row = pos / H;
          acc = (col % 2 == 1) && (row % 2 == 1);
          pos = (pos + 1) % NPIX;
        end
      end
    end
    acc_h[t] = acc;
    @(posedge clk);
    #1;
    if (t == 0 || f || frst_h[t-1]) begin
      ev = 1'b0; evs = 1'b0; ehs = 1'b0;
    end else begin
      ev = acc_h[t-1]; evs = vs_h[t-1]; ehs = hs_h[t-1];
    end
    if (!rst_n) last_data = '0;
    else if (ev) last_data = dat_h[t-1];
    check("valid", {23'b0, o_valid}, {23'b0, ev});
    check("data", o_data, last_data);
    check("vs", {23'b0, o_vs}, {23'b0, evs});
    check("hs", {23'b0, o_hs}, {23'b0, ehs});
    if (o_valid === 1'b1) begin
      out_cnt++;
      dut_last = o_data;
      $display("t=%0d pixel out %h", t, o_data);
    end
    t++;
  endtask

  task automatic set_window(input int mode);
    case (mode)
      0: begin d0 = 24'h102030; d1 = 24'h102030; d2 = 24'h102030; d3 = 24'h102030; end
      1: begin d0 = 24'h010000; d1 = 24'h020000; d2 = 24'h030000; d3 = 24'h000000; end
      2: begin d0 = 24'hFFFFFF; d1 = 24'hFFFFFF; d2 = 24'hFFFFFF; d3 = 24'hFFFFFF; end
      default: begin
        d0 = 24'($urandom); d1 = 24'($urandom); d2 = 24'($urandom); d3 = 24'($urandom);
      end
    endcase
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    hs = 1'b0;
    repeat (n) tick();
  endtask

  task automatic vs_pulse();
    valid = 1'b0;
    vs = 1'b1;
    tick();
    vs = 1'b0;
  endtask

  task automatic pixel(input int mode, input int col);
    valid = 1'b1;
    hs = (col == 0);
    set_window(mode);
    tick();
    valid = 1'b0;
    hs = 1'b0;
  endtask

  task automatic send_frame(input int mode, input bit gaps);
    for (int p = 0; p < NPIX; p++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 1));
      pixel(mode, p % H);
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) tick();
    check("rst_data", o_data, 24'h0);
    check("rst_valid", {23'b0, o_valid}, 24'h0);
    rst_n = 1'b1;
    idle(2);

    // Uniform frame: one output per 2x2 block, value unchanged.
    vs_pulse();
    out_cnt = 0;
    send_frame(0, 1'b0);
    idle(3);
    check("uniform_count", 24'(out_cnt), 24'(NPIX / 4));
    check("uniform_value", dut_last, 24'h102030);

    // Rounding behaviour with R channel values 1,2,3,0.
    vs_pulse();
    send_frame(1, 1'b0);
    idle(3);
    check("round_r", {16'b0, dut_last[23:16]}, ROUND_R);

    // Full-scale window must not overflow.
    vs_pulse();
    send_frame(2, 1'b0);
    idle(3);
    check("full_scale", dut_last, 24'hFFFFFF);

    // Random data with gaps in valid.
    for (int k = 0; k < 2; k++) begin
      vs_pulse();
      out_cnt = 0;
      send_frame(3, 1'b1);
      idle(3);
      check("rand_count", 24'(out_cnt), 24'(NPIX / 4));
    end

    // frame_rst together with a valid at col 5, row 3.
    vs_pulse();
    for (int p = 0; p < 3 * H + 5; p++) pixel(3, p % H);
    frame_rst = 1'b1;
    pixel(3, 5);
    frame_rst = 1'b0;
    out_cnt = 0;
    send_frame(3, 1'b0);
    idle(3);
    check("frst_count", 24'(out_cnt), 24'(NPIX / 4));

    // vs rising edge mid-line at col 7 restarts the frame on that pixel.
    vs_pulse();
    for (int p = 0; p < 7; p++) pixel(3, p);
    out_cnt = 0;
    vs = 1'b1;
    pixel(3, 0);
    vs = 1'b0;
    for (int p = 1; p < NPIX; p++) pixel(3, p % H);
    idle(3);
    check("vs_mid_count", 24'(out_cnt), 24'(NPIX / 4));

    // Asynchronous reset mid-frame clears outputs without a clock edge.
    vs_pulse();
    for (int p = 0; p < 13; p++) pixel(2, p % H);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data", o_data, 24'h0);
    check("arst_valid", {23'b0, o_valid}, 24'h0);
    tick();
    rst_n = 1'b1;
    vs_pulse();
    out_cnt = 0;
    send_frame(3, 1'b0);
    idle(3);
    check("post_arst_count", 24'(out_cnt), 24'(NPIX / 4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
